// File: rtl/freq_meter_pkg.sv
// freq_meter_pkg: items shared by the frequency meter and its sub-module.
//   state_t     - measurement FSM states (IDLE, MEAS, DONE)
//   SYNC_STAGES - depth of the input synchronizer ahead of the history flop
//   sat_inc     - increment that holds at a ceiling instead of wrapping
package freq_meter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEAS = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int SYNC_STAGES = 2;

  // Works on 32-bit containers so that any counter width up to 32 can use it;
  // callers cast the argument up and the result back down to their own width.
  function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                          input logic [31:0] max_val);
    return (value >= max_val) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/freq_meter_edge_detect.sv
// edge_detect: brings an asynchronous slow signal into the clk domain and
// flags its transitions. A SYNC_STAGES-deep synchronizer feeds one history
// flop; rise/any_edge compare the synchronizer output against that history.
// Ports:
//   clk      - sole clock
//   rst      - synchronous active-high reset (all flops to 0)
//   sig_in   - asynchronous input
//   rise     - one-cycle pulse per 0->1 transition
//   any_edge - one-cycle pulse per transition in either direction
module edge_detect
  import freq_meter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic sig_in,
  output logic rise,
  output logic any_edge
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   hist_reg;
  logic                   synced;

  assign synced = sync_reg[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg <= '0;
      hist_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], sig_in};
      hist_reg <= synced;
    end
  end

  assign rise     = synced & ~hist_reg;
  assign any_edge = synced ^ hist_reg;

endmodule

// File: rtl/freq_meter.sv
// freq_meter: counts rising and total edges of sig_in over a gate window of
// GATE_CYCLES clk cycles after a start pulse, then presents the results with
// a one-cycle done strobe. Results hold until the next window completes.
// Optional feature macro: FREQ_METER_PERIOD_EN adds min/max rise-to-rise
// period measurement (period_min / period_max ports).
// Ports:
//   clk, rst        - clock and synchronous active-high reset
//   sig_in          - asynchronous signal under measurement
//   start           - begin a measurement (only honoured while idle)
//   busy            - window open
//   done            - one-cycle strobe, results valid from this cycle
//   rise_cnt        - rising edges in the last window (saturating)
//   edge_cnt        - total edges in the last window (saturating)
//   ovf             - a counter saturated in the last window
//   period_min/max  - (FREQ_METER_PERIOD_EN) shortest/longest rise-to-rise
//                     spacing in clk cycles, 0 with fewer than two rises
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int GATE_CYCLES = 100,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] rise_cnt,
  output logic [CNT_W-1:0] edge_cnt,
  output logic             ovf
`ifdef FREQ_METER_PERIOD_EN
  ,
  output logic [CNT_W-1:0] period_min,
  output logic [CNT_W-1:0] period_max
`endif
);

  localparam int              GATE_W    = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [31:0]     CNT_MAX32 = 32'((64'd1 << CNT_W) - 64'd1);
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

  logic rise;
  logic any_edge;

  edge_detect u_edge_detect (
    .clk      (clk),
    .rst      (rst),
    .sig_in   (sig_in),
    .rise     (rise),
    .any_edge (any_edge)
  );

  state_t            state_reg, state_next;
  logic [GATE_W-1:0] gate_cnt_reg;
  logic              gate_last;
  logic [CNT_W-1:0]  rise_work_reg, rise_work_next;
  logic [CNT_W-1:0]  edge_work_reg, edge_work_next;
  logic              ovf_work_reg, ovf_work_next;
  logic              done_reg;
  logic [CNT_W-1:0]  rise_cnt_reg, edge_cnt_reg;
  logic              ovf_reg;

  assign gate_last = (gate_cnt_reg == GATE_LAST);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = MEAS;
      MEAS:    if (gate_last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Next values of the working counters include the current cycle's edge so
  // the final MEAS cycle can be folded straight into the output registers.
  always_comb begin
    rise_work_next = rise_work_reg;
    edge_work_next = edge_work_reg;
    ovf_work_next  = ovf_work_reg;
    if (rise) begin
      rise_work_next = CNT_W'(sat_inc(32'(rise_work_reg), CNT_MAX32));
      if (rise_work_reg == CNT_MAX) ovf_work_next = 1'b1;
    end
    if (any_edge) begin
      edge_work_next = CNT_W'(sat_inc(32'(edge_work_reg), CNT_MAX32));
      if (edge_work_reg == CNT_MAX) ovf_work_next = 1'b1;
    end
  end

`ifdef FREQ_METER_PERIOD_EN
  logic [CNT_W-1:0] timer_reg, timer_next;
  logic             armed_reg, armed_next;
  logic             have_reg, have_next;
  logic [CNT_W-1:0] pmin_work_reg, pmin_work_next;
  logic [CNT_W-1:0] pmax_work_reg, pmax_work_next;
  logic [CNT_W-1:0] period_min_reg, period_max_reg;

  // The first rise only arms the timer; every later rise closes one period
  // (the timer value) and restarts counting at 1 for the following cycle.
  always_comb begin
    timer_next     = CNT_W'(sat_inc(32'(timer_reg), CNT_MAX32));
    armed_next     = armed_reg;
    have_next      = have_reg;
    pmin_work_next = pmin_work_reg;
    pmax_work_next = pmax_work_reg;
    if (rise) begin
      if (armed_reg) begin
        have_next = 1'b1;
        if (timer_reg < pmin_work_reg) pmin_work_next = timer_reg;
        if (timer_reg > pmax_work_reg) pmax_work_next = timer_reg;
      end
      timer_next = CNT_W'(1);
      armed_next = 1'b1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      gate_cnt_reg  <= '0;
      rise_work_reg <= '0;
      edge_work_reg <= '0;
      ovf_work_reg  <= 1'b0;
      done_reg      <= 1'b0;
      rise_cnt_reg  <= '0;
      edge_cnt_reg  <= '0;
      ovf_reg       <= 1'b0;
`ifdef FREQ_METER_PERIOD_EN
      timer_reg      <= '0;
      armed_reg      <= 1'b0;
      have_reg       <= 1'b0;
      pmin_work_reg  <= CNT_MAX;
      pmax_work_reg  <= '0;
      period_min_reg <= '0;
      period_max_reg <= '0;
`endif
    end else begin
      state_reg <= state_next;
      done_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            gate_cnt_reg  <= '0;
            rise_work_reg <= '0;
            edge_work_reg <= '0;
            ovf_work_reg  <= 1'b0;
`ifdef FREQ_METER_PERIOD_EN
            timer_reg     <= '0;
            armed_reg     <= 1'b0;
            have_reg      <= 1'b0;
            pmin_work_reg <= CNT_MAX;
            pmax_work_reg <= '0;
`endif
          end
        end
        MEAS: begin
          gate_cnt_reg  <= gate_cnt_reg + GATE_W'(1);
          rise_work_reg <= rise_work_next;
          edge_work_reg <= edge_work_next;
          ovf_work_reg  <= ovf_work_next;
`ifdef FREQ_METER_PERIOD_EN
          timer_reg     <= timer_next;
          armed_reg     <= armed_next;
          have_reg      <= have_next;
          pmin_work_reg <= pmin_work_next;
          pmax_work_reg <= pmax_work_next;
`endif
          // Load results on the closing edge so they are valid alongside done.
          if (gate_last) begin
            rise_cnt_reg <= rise_work_next;
            edge_cnt_reg <= edge_work_next;
            ovf_reg      <= ovf_work_next;
            done_reg     <= 1'b1;
`ifdef FREQ_METER_PERIOD_EN
            period_min_reg <= have_next ? pmin_work_next : '0;
            period_max_reg <= have_next ? pmax_work_next : '0;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign busy     = (state_reg == MEAS);
  assign done     = done_reg;
  assign rise_cnt = rise_cnt_reg;
  assign edge_cnt = edge_cnt_reg;
  assign ovf      = ovf_reg;
`ifdef FREQ_METER_PERIOD_EN
  assign period_min = period_min_reg;
  assign period_max = period_max_reg;
`endif

endmodule

// File: doc/freq_meter.md
# freq_meter

Hardware counterpart of the frequency divider: measures a single-bit input waveform over a fixed gate window of `clk` cycles. On a `start` pulse it counts rising and total edges of `sig_in`, then reports the results with a one-cycle `done` strobe. It sits downstream of divider outputs (or any slow periodic signal) so divide ratios can be checked in-circuit instead of only in simulation.

## Interface

**Parameters**
- `GATE_CYCLES`, default 100: measurement window length in `clk` cycles; must be ≥ 2.
- `CNT_W`, default 16: width of the edge counters and period registers.

**Ports**
- `clk`, input, 1: sole clock; all logic on its rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `sig_in`, input, 1: asynchronous signal under measurement.
- `start`, input, 1: single-cycle request to begin a measurement; honoured only in IDLE.
- `busy`, output, 1: high while a measurement window is open.
- `done`, output, 1: one-cycle strobe; results are valid from this cycle on.
- `rise_cnt`, output, CNT_W: rising edges seen in the last window.
- `edge_cnt`, output, CNT_W: total edges (rise + fall) seen in the last window.
- `ovf`, output, 1: a counter saturated during the last window.
- `period_min`, output, CNT_W: present only with FREQ_METER_PERIOD_EN.
- `period_max`, output, CNT_W: present only with FREQ_METER_PERIOD_EN.

## Operation

- **Input conditioning**: 2-flop synchronizer (`s1`, `s2`) feeds history flop `s3`.
  - `rise = s2 & ~s3`
  - `edge = s2 ^ s3`
  - All three flops reset to 0.
- **FSM states**: IDLE → MEAS → DONE → IDLE.
  - IDLE: `start=1` moves to MEAS and clears `gate_cnt` and the working counters.
  - MEAS: `busy=1`; `gate_cnt` increments each cycle. Cycle k (0..GATE_CYCLES-1) adds `rise` and `edge` into the working counters. Leaves after the cycle where `gate_cnt == GATE_CYCLES-1`.
  - DONE: working counters copy into the output registers, `done=1`, then return to IDLE.
- **Ignored starts**: `start` is ignored in MEAS and DONE. Nothing is queued.
- **Saturation**: working counters saturate at 2^CNT_W-1 and do not wrap. Any saturation sets the working ovf flag, which is copied to `ovf` in DONE.
- **Output hold**: output registers hold their values until the next DONE or reset.
- **Reset**: `rst` asserted in any state → IDLE next cycle. The partial window is discarded and `done` does not fire for it.

## Timing

- **Reset values**:
  - `busy`, `done`, `ovf` = 0.
  - `rise_cnt`, `edge_cnt`, `period_min`, `period_max` = 0.
  - FSM state = IDLE.
- **Start-to-busy**: `start` sampled at edge N → `busy` high from N+1 for exactly GATE_CYCLES cycles. `done` is high at N+1+GATE_CYCLES.
- **Input latency**: a `sig_in` transition is counted 3 `clk` edges after it is sampled by `s1`. Transitions within the last 3 cycles before the window closes fall into the next window, or are lost if no window follows.
- **Back-to-back**: `start` in the same cycle as DONE is ignored. The earliest accepted restart is the cycle after `done`.
- **Post-reset**: a `start` within 3 cycles of reset release while `sig_in=1` counts one spurious rise. Stimulus must wait ≥ 3 cycles.
- **Edge rates**:
  - Maximum measurable rate is a toggle every `clk` (`edge_cnt` = GATE_CYCLES).
  - Input toggling faster than `clk` aliases; no detection is provided.

## Configuration

- **Macro**: `FREQ_METER_PERIOD_EN`.
- **Defined**:
  - A period timer counts `clk` cycles between consecutive rises inside MEAS. The first rise only arms the timer.
  - Each later rise updates the working min and max, then restarts the timer.
  - The timer saturates at 2^CNT_W-1 without setting `ovf`.
  - DONE copies min and max to the outputs. With fewer than 2 rises in the window, both report 0.
- **Undefined**: the timer, the `period_min` and `period_max` ports, and their registers are absent.

## Structure

- **Shared package `freq_meter_pkg`**:
  - FSM state enum (IDLE, MEAS, DONE).
  - Localparam for synchronizer depth (2).
  - Saturating-increment function.
- **Sub-module `edge_detect`**: synchronizer plus history flop, with outputs `rise` and `edge`. It is reused by other slow-signal monitors.

## Test plan

- Divide-by-4 input (toggle every 2 `clk`), GATE_CYCLES=100, `start` once → `rise_cnt`=25, `edge_cnt`=50, `ovf`=0, `done` at cycle 101 after `start`.
- `sig_in` held at 0, then held at 1 (after a ≥ 3-cycle settle) → `rise_cnt`=0, `edge_cnt`=0 in both runs.
- Toggle every `clk` → `edge_cnt`=100, `rise_cnt`=50. With the macro defined → `period_min`=`period_max`=2.
- CNT_W=4, toggle every `clk` → `rise_cnt`=15, `edge_cnt`=15, `ovf`=1.
- `start` re-pulsed at cycle 40 of MEAS → ignored; exactly one `done`, at cycle 101.
- `rst` asserted at cycle 50 of MEAS → `busy`=0 the next cycle, no `done`, outputs 0. A fresh `start` afterwards gives correct counts.
